// File: rtl/ps2_scan_ctrl_if.sv
// ps2_scan_ctrl_if: key-event stream from the PS/2 scan controller to its consumer.
//   evt_code   8  key code at the FIFO head
//   evt_ext    1  head event was E0-prefixed
//   evt_break  1  head event is a key release
//   evt_valid  1  an event is available (FIFO not empty)
//   evt_ready  1  consumer accepts the head event this cycle
// master = event producer (ps2_scan_ctrl), slave = consumer.
interface ps2_scan_ctrl_if;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_valid;
  logic       evt_ready;

  modport master (
    output evt_code,
    output evt_ext,
    output evt_break,
    output evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_code,
    input  evt_ext,
    input  evt_break,
    input  evt_valid,
    output evt_ready
  );
endinterface

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: main-clock side of the PS/2 receiver. Synchronises the
// byte-valid level, captures each byte, folds set-2 E0/F0 prefixes into single
// key events and queues them in a first-word-fall-through FIFO.
// Ports:
//   Clk, nReset          main clock, async active-low reset
//   rx_data[7:0]         received byte (stable while rx_valid high)
//   rx_valid             byte-valid level from the PS/2 clock domain
//   rx_parity_ok         parity result for rx_data
//   evt (master)         event stream: code/ext/break/valid out, ready in
//   fifo_count           current FIFO occupancy
//   overflow             sticky, an event was dropped on a full FIFO
//   err_count[7:0]       saturating parity/timeout/device-error count
//   clear_err            synchronous clear of overflow and err_count
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to suppress typematic
// repeats of the currently held key.
module ps2_scan_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                        Clk,
  input  logic                        nReset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_parity_ok,
  ps2_scan_ctrl_if.master             evt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [7:0]                  err_count,
  input  logic                        clear_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  // Synchroniser and byte capture
  logic       s1, s2, s3;
  logic       cap_v;
  logic [7:0] byte_r;
  logic       par_r;
  logic       strobe_c;

  assign strobe_c = s2 & ~s3;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      cap_v  <= 1'b0;
      byte_r <= 8'h00;
      par_r  <= 1'b0;
    end else begin
      s1    <= rx_valid;
      s2    <= s1;
      s3    <= s2;
      cap_v <= strobe_c;
      if (strobe_c) begin
        byte_r <= rx_data;
        par_r  <= rx_parity_ok;
      end
    end
  end

  // Prefix decoder: acts on the cycle after capture
  state_t         state, state_nxt;
  logic [TW-1:0]  tmo_cnt;
  logic           tmo_hit_c;
  logic           dec_v;
  evt_t           dec_evt;
  logic           err_inc;

  assign tmo_hit_c = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt    = state;
    dec_v        = 1'b0;
    dec_evt.code = byte_r;
    dec_evt.ext  = 1'b0;
    dec_evt.brk  = 1'b0;
    err_inc      = 1'b0;
    if (cap_v) begin
      if (!par_r) begin
        err_inc   = 1'b1;
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            case (byte_r)
              8'hE0:                      state_nxt = GOT_E0;
              8'hF0:                      state_nxt = GOT_F0;
              8'h00, 8'hFF:               err_inc   = 1'b1;
              8'hAA, 8'hFA, 8'hFE, 8'hEE: ;  // BAT / ack / resend / echo
              default:                    dec_v     = 1'b1;
            endcase
          end
          GOT_E0: begin
            if (byte_r == 8'hF0) begin
              state_nxt = GOT_E0F0;
            end else if (byte_r != 8'hE0) begin
              dec_v       = 1'b1;
              dec_evt.ext = 1'b1;
              state_nxt   = IDLE;
            end
          end
          GOT_F0: begin
            dec_v       = 1'b1;
            dec_evt.brk = 1'b1;
            state_nxt   = IDLE;
          end
          GOT_E0F0: begin
            dec_v       = 1'b1;
            dec_evt.ext = 1'b1;
            dec_evt.brk = 1'b1;
            state_nxt   = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (tmo_hit_c) begin
      err_inc   = 1'b1;
      state_nxt = IDLE;
    end
  end

  // State and prefix timeout counter
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || strobe_c || cap_v || tmo_hit_c) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // Push qualification (optionally drops repeats of the held key)
  logic push_c;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_v;
  logic [7:0] held_code;
  logic       held_ext;
  logic       held_match_c;

  assign held_match_c = held_v && (held_code == dec_evt.code) && (held_ext == dec_evt.ext);
  assign push_c       = dec_v & ~(~dec_evt.brk & held_match_c);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      held_v    <= 1'b0;
      held_code <= 8'h00;
      held_ext  <= 1'b0;
    end else if (dec_v) begin
      if (!dec_evt.brk) begin
        held_v    <= 1'b1;
        held_code <= dec_evt.code;
        held_ext  <= dec_evt.ext;
      end else if (held_match_c) begin
        held_v <= 1'b0;
      end
    end
  end
`else
  assign push_c = dec_v;
`endif

  // Event FIFO (first-word fall-through)
  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, cnt_nxt;
  logic          valid_r;
  logic          full_c, pop_c, wr_c;

  assign full_c = (count == CW'(FIFO_DEPTH));
  assign pop_c  = valid_r & evt.evt_ready;
  assign wr_c   = push_c & (~full_c | pop_c);

  always_comb begin
    cnt_nxt = count;
    case ({wr_c, pop_c})
      2'b10:   cnt_nxt = count + CW'(1);
      2'b01:   cnt_nxt = count - CW'(1);
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_r <= 1'b0;
    end else begin
      if (wr_c) begin
        mem[wr_ptr] <= dec_evt;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      count   <= cnt_nxt;
      valid_r <= (cnt_nxt != '0);
    end
  end

  // Sticky overflow and saturating error counter; clear wins
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      overflow  <= 1'b0;
      err_count <= 8'h00;
    end else if (clear_err) begin
      overflow  <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (push_c && full_c && !pop_c) overflow <= 1'b1;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign evt.evt_valid = valid_r;
  assign evt.evt_code  = mem[rd_ptr].code;
  assign evt.evt_ext   = mem[rd_ptr].ext;
  assign evt.evt_break = mem[rd_ptr].brk;
  assign fifo_count    = count;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb_ps2_scan_ctrl: self-checking bench for ps2_scan_ctrl. Byte streams are
// scored against a prefix/queue model of the scan-code rules.
module tb_ps2_scan_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 64;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          nReset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_parity_ok;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [7:0]    err_count;
  logic          clear_err;

  ps2_scan_ctrl_if evt_if ();

  ps2_scan_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk          (Clk),
    .nReset       (nReset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_ok (rx_parity_ok),
    .evt          (evt_if),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .err_count    (err_count),
    .clear_err    (clear_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: event = {code, ext, brk}
  logic [9:0] exp_q [$];
  logic [9:0] got_q [$];
  int         err_exp;
  bit         ovf_exp;
  bit         m_ext, m_brk;
  bit         held_v;
  logic [8:0] held;

  task automatic model_reset();
    exp_q.delete();
    err_exp = 0;
    ovf_exp = 0;
    m_ext   = 0;
    m_brk   = 0;
    held_v  = 0;
    held    = '0;
  endtask

  task automatic model_err();
    if (err_exp < 255) err_exp++;
  endtask

  task automatic model_push(input logic [7:0] c, input bit e, input bit b);
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (!b) begin
      if (held_v && held == {c, e}) return;
      held   = {c, e};
      held_v = 1;
    end else if (held_v && held == {c, e}) begin
      held_v = 0;
    end
`endif
    if (exp_q.size() >= int'(DEPTH)) ovf_exp = 1;
    else exp_q.push_back({c, e, b});
  endtask

  task automatic model_byte(input logic [7:0] b, input bit par);
    if (!par) begin
      model_err();
      m_ext = 0;
      m_brk = 0;
    end else if (m_brk) begin
      model_push(b, m_ext, 1'b1);
      m_ext = 0;
      m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        model_push(b, 1'b1, 1'b0);
        m_ext = 0;
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'h00, 8'hFF: model_err();
        8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
        default: model_push(b, 1'b0, 1'b0);
      endcase
    end
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    nReset   = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    model_reset();
    @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit par, input int hold, input int low);
    @(negedge Clk);
    rx_data      = b;
    rx_parity_ok = par;
    rx_valid     = 1'b1;
    repeat (hold) @(negedge Clk);
    rx_valid = 1'b0;
    repeat (low) @(negedge Clk);
    model_byte(b, par);
  endtask

  task automatic pulse_clear();
    @(negedge Clk);
    clear_err = 1'b1;
    @(negedge Clk);
    clear_err = 1'b0;
    err_exp   = 0;
    ovf_exp   = 0;
  endtask

  // Collects every queued event by popping one per handshake
  task automatic pop_all();
    got_q.delete();
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      if (!evt_if.evt_valid) break;
      got_q.push_back({evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break});
      evt_if.evt_ready = 1'b1;
      @(negedge Clk);
      evt_if.evt_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", evt_if.evt_valid); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
    checks++; if ({evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break} !== 10'h0) begin
      errors++; $display("FAIL reset_head got %h want 000", {evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break});
    end
  endtask

  task automatic test_basic();
    send_byte(8'h1C, 1, 4, 4);
    send_byte(8'hF0, 1, 4, 4);
    send_byte(8'h1C, 1, 4, 4);
    checks++; if (fifo_count !== CW'(exp_q.size())) begin errors++; $display("FAIL basic_count got %0d want %0d", fifo_count, exp_q.size()); end
    pop_all();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL basic_n got %0d want 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_evt%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_count !== 8'(err_exp)) begin errors++; $display("FAIL basic_err got %0d want %0d", err_count, err_exp); end
    exp_q.delete();
  endtask

  task automatic test_ext();
    send_byte(8'hE0, 1, 4, 4);
    send_byte(8'h75, 1, 4, 4);
    send_byte(8'hE0, 1, 4, 4);
    send_byte(8'hF0, 1, 4, 4);
    send_byte(8'h75, 1, 4, 4);
    pop_all();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ext_n got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ext_evt%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    send_byte(8'hF0, 1, 4, 4);
    repeat (TMO + 20) @(negedge Clk);
    model_err();
    m_ext = 0;
    m_brk = 0;
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL tmo_valid got %0b want 0", evt_if.evt_valid); end
    checks++; if (err_count !== 8'(err_exp)) begin errors++; $display("FAIL tmo_err got %0d want %0d", err_count, err_exp); end
    send_byte(8'h1C, 1, 4, 4);
    pop_all();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL tmo_n got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tmo_evt%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_errors();
    pulse_clear();
    send_byte(8'h1C, 0, 4, 4);
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL par_err got %0d want 1", err_count); end
    send_byte(8'hAA, 1, 4, 4);
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL bat_valid got %0b want 0", evt_if.evt_valid); end
    send_byte(8'hFF, 1, 4, 4);
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL ff_err got %0d want 2", err_count); end
    checks++; if (err_count !== 8'(err_exp)) begin errors++; $display("FAIL err_model got %0d want %0d", err_count, err_exp); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    pulse_clear();
    for (int i = 0; i < int'(DEPTH) + 1; i++) send_byte(codes[i], 1, 4, 4);
    checks++; if (fifo_count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count got %0d want %0d", fifo_count, DEPTH); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    pop_all();
    checks++; if (got_q.size() !== int'(DEPTH)) begin errors++; $display("FAIL ovf_n got %0d want %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== {codes[i], 2'b00}) begin errors++; $display("FAIL ovf_evt%0d got %h want %h", i, got_q[i], {codes[i], 2'b00}); end
    end
    exp_q.delete();
  endtask

  task automatic test_clear();
    pulse_clear();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b want 0", overflow); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL clr_err got %0d want 0", err_count); end
  endtask

  task automatic test_typematic();
    int n_exp;
`ifdef PS2_TYPEMATIC_FILTER_EN
    n_exp = 2;
`else
    n_exp = 4;
`endif
    send_byte(8'h1C, 1, 4, 4);
    send_byte(8'h1C, 1, 4, 4);
    send_byte(8'h1C, 1, 4, 4);
    send_byte(8'hF0, 1, 4, 4);
    send_byte(8'h1C, 1, 4, 4);
    pop_all();
    checks++; if (got_q.size() !== n_exp) begin errors++; $display("FAIL typ_n got %0d want %0d", got_q.size(), n_exp); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL typ_evt%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [8];
    seq = '{8'h1C, 8'hE0, 8'h75, 8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75};
    for (int i = 0; i < 8; i++) send_byte(seq[i], 1, 3, 1);
    pop_all();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_n got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_evt%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_saturate();
    pulse_clear();
    for (int i = 0; i < 260; i++) send_byte(8'hFF, 1, 3, 1);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_err got %0d want 255", err_count); end
    pulse_clear();
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         par;
    logic [7:0] specials [6];
    specials = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 10; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: b = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
          3:       b = specials[$urandom_range(0, 5)];
          default: b = 8'($urandom_range(1, 8'h7F));
        endcase
        par = ($urandom_range(0, 9) != 0);
        send_byte(b, par, $urandom_range(3, 5), $urandom_range(1, 4));
      end
      checks++; if (overflow !== ovf_exp) begin errors++; $display("FAIL rnd%0d_ovf got %0b want %0b", r, overflow, ovf_exp); end
      checks++; if (err_count !== 8'(err_exp)) begin errors++; $display("FAIL rnd%0d_err got %0d want %0d", r, err_count, err_exp); end
      pop_all();
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_n got %0d want %0d", r, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_evt%0d got %h want %h", r, i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h15, 1, 4, 4);
    send_byte(8'hE0, 1, 4, 4);
    apply_reset();
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", evt_if.evt_valid); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rstmid_count got %0d want 0", fifo_count); end
    send_byte(8'h75, 1, 4, 4);
    pop_all();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rstmid_n got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== {8'h75, 2'b00}) begin errors++; $display("FAIL rstmid_evt got %h want %h", got_q[0], {8'h75, 2'b00}); end
    end
    exp_q.delete();
  endtask

  initial begin
    nReset           = 1'b0;
    rx_data          = 8'h00;
    rx_valid         = 1'b0;
    rx_parity_ok     = 1'b1;
    clear_err        = 1'b0;
    evt_if.evt_ready = 1'b0;
    apply_reset();
    test_reset();
    test_basic();
    test_ext();
    test_timeout();
    test_errors();
    test_overflow();
    test_clear();
    test_typematic();
    test_back_to_back();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_ctrl.md
# ps2_scan_ctrl

Main-clock controller for the PS/2 receiver. It synchronises the receiver's byte-valid strobe out of the PS/2 clock domain and captures each byte. It decodes the scan-code set 2 prefixes (E0 extended, F0 break) into single key events and buffers those events in a first-word-fall-through FIFO. Consumers (encryption / secure-wire blocks) pop events with a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 50000: Clk cycles allowed between a prefix byte and the byte that completes it (1 ms at 50 MHz).
- Clk  input  1  main clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from the receiver; stable while rx_valid is high.
- rx_valid  input  1  byte-valid level from the PS/2 clock domain; asynchronous to Clk.
- rx_parity_ok  input  1  parity result for rx_data; stable while rx_valid is high.
- evt_code  output  8  key code at the FIFO head.
- evt_ext  output  1  head event was E0-prefixed.
- evt_break  output  1  head event is a key release.
- evt_valid  output  1  FIFO not empty.
- evt_ready  input  1  consumer accepts the head event.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; an event was dropped because the FIFO was full.
- err_count  output  8  saturating count of parity, timeout and device-error bytes.
- clear_err  input  1  synchronous clear of overflow and err_count.

## Operation
- Synchroniser: rx_valid passes through flops s1 and s2, then a delay flop s3. The capture strobe is s2 & ~s3. On the strobe, rx_data and rx_parity_ok are registered into byte_r and par_r.
- Decoder FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. It acts one cycle after capture.
- Bytes with par_r = 0: discarded; err_count +1; FSM goes to IDLE.
- IDLE on E0: go to GOT_E0.
- IDLE on F0: go to GOT_F0.
- IDLE on 00 or FF: err_count +1.
- IDLE on AA, FA, FE or EE: dropped silently (BAT / ack / resend / echo).
- IDLE on any other byte: push {code, ext=0, brk=0}.
- GOT_E0 on F0: go to GOT_E0F0.
- GOT_E0 on E0: stay in GOT_E0.
- GOT_E0 on any other byte: push {code, 1, 0}, then IDLE.
- GOT_F0 on any byte: push {code, 0, 1}, then IDLE.
- GOT_E0F0 on any byte: push {code, 1, 1}, then IDLE.
- Timeout: a counter runs while the FSM is not in IDLE and clears on every capture. On reaching TIMEOUT_CYCLES-1 the FSM goes to IDLE and err_count +1.
- FIFO: first-word fall-through. Pop when evt_valid & evt_ready.
- Push to a full FIFO with no pop that cycle: the event is dropped and overflow is set.
- Push and pop in the same cycle when full: both occur, count is unchanged, no overflow.
- Pointers wrap modulo FIFO_DEPTH.
- err_count saturates at 255.
- clear_err has priority over a same-cycle increment: the result is 0.
- Reset values: all state flops 0, FSM in IDLE, FIFO empty, evt_valid 0, evt_code/evt_ext/evt_break 0, fifo_count 0, overflow 0, err_count 0.
- nReset asserted mid-frame or mid-prefix discards all partial state and buffered events.

## Timing
- rx_valid sampled high at Clk edge k:
  - s2 = 1 after edge k+1.
  - Capture occurs at edge k+2.
  - FSM update and FIFO write occur at edge k+3.
  - evt_valid is high after edge k+3 when the FIFO was empty.
- rx_valid must stay high for at least 3 Clk cycles. A new byte is recognised only after rx_valid has been seen low for at least 1 cycle.
- Back-to-back bytes are accepted at any PS/2 rate (≥ 11 PS/2 clocks apart).
- Pop takes effect at the edge where evt_valid & evt_ready. The next head, or evt_valid = 0, is visible after that edge.

## Configuration
- PS2_TYPEMATIC_FILTER_EN defined:
  - A held-key register {code, ext} plus a held flag suppresses typematic repeats.
  - A make event equal to the held key is not pushed.
  - A break of the held key clears the held flag.
  - A different make replaces the held key.
  - The register clears on reset.
- PS2_TYPEMATIC_FILTER_EN undefined: every decoded make is pushed; no extra state is built.

## Test plan
- Bytes 1C, F0 1C -> two events {1C,0,0} then {1C,0,1}; err_count 0.
- Bytes E0 75, E0 F0 75 -> {75,1,0} then {75,1,1}.
- Byte F0, then no byte for TIMEOUT_CYCLES -> no event, err_count = 1, FSM in IDLE; next byte 1C -> {1C,0,0}.
- Byte 1C with rx_parity_ok = 0 -> no event, err_count = 1. AA -> no event. FF -> err_count = 2.
- evt_ready held low, FIFO_DEPTH+1 distinct makes -> fifo_count = FIFO_DEPTH, overflow = 1, first FIFO_DEPTH events pop in order.
- PS2_TYPEMATIC_FILTER_EN defined: 1C 1C 1C F0 1C -> exactly {1C,0,0} and {1C,0,1}. Undefined: four events.
